bicubic_tap_window: RTL

//  Upstream feeder for the 4-tap bicubic weight-sum stage.

---
 rtl/bicubic_tap_window.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bicubic_tap_window.sv
// ---------------------------------------------------------------------------
// bicubic_tap_window
//   Feeder for the 4-tap bicubic weight-sum stage. Accepts a raster pixel
//   stream one row at a time and presents, for every column x of the row, the
//   horizontal window (p[x-1], p[x], p[x+1], p[x+2]). Out-of-row indices are
//   clamped to the row, so the edge pixels are replicated. Exactly LINE_W
//   windows are produced per row; both sides use a valid/ready handshake.
//
// Parameters
//   PIX_W   bits per pixel
//   LINE_W  pixels per row (>= 3)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   pix_in     input pixel
//   pix_valid  pix_in is valid
//   pix_ready  block accepts pix_in this cycle
//   tap_0..3   window taps p[x-1], p[x], p[x+1], p[x+2] (clamped)
//   tap_valid  taps hold a valid window
//   tap_ready  downstream consumes the window
//   tap_last   window is the last column of the row
// ---------------------------------------------------------------------------
module bicubic_tap_window #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LINE_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] tap_0,
    output logic [PIX_W-1:0] tap_1,
    output logic [PIX_W-1:0] tap_2,
    output logic [PIX_W-1:0] tap_3,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic             tap_last
);

    localparam int unsigned   CW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_W - 1);
    localparam logic [CW-1:0] P2_IDX   = CW'(2);

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic             fl_cnt_q, fl_cnt_d;
    logic [PIX_W-1:0] r_q [4];
    logic [PIX_W-1:0] r_d [4];
    logic             tap_valid_q, tap_valid_d;
    logic             tap_last_q, tap_last_d;

    logic adv;
    logic accept;

    // Output slot is free when empty or being consumed this cycle.
    assign adv       = !tap_valid_q || tap_ready;
    assign pix_ready = (state_q != FLUSH) && adv;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        fl_cnt_d    = fl_cnt_q;
        r_d         = r_q;
        tap_valid_d = tap_valid_q;
        tap_last_d  = tap_last_q;

        // Nothing moves while a window is stalled downstream.
        if (adv) begin
            // Any free-slot cycle without a new window leaves the slot empty.
            tap_valid_d = 1'b0;
            tap_last_d  = 1'b0;
            unique case (state_q)
                FILL, RUN: begin
                    if (accept) begin
                        if (state_q == FILL && in_cnt_q == '0) begin
                            // First pixel fills every tap: left-edge replication.
                            r_d[0] = pix_in;
                            r_d[1] = pix_in;
                            r_d[2] = pix_in;
                            r_d[3] = pix_in;
                        end else begin
                            r_d[0] = r_q[1];
                            r_d[1] = r_q[2];
                            r_d[2] = r_q[3];
                            r_d[3] = pix_in;
                        end
                        tap_valid_d = (state_q == RUN) || (in_cnt_q == P2_IDX);
                        if (in_cnt_q == LAST_IDX) begin
                            // Row end wins over FILL->RUN so LINE_W == 3 flushes directly.
                            state_d  = FLUSH;
                            in_cnt_d = '0;
                        end else begin
                            in_cnt_d = in_cnt_q + CW'(1);
                            if (state_q == FILL && in_cnt_q == P2_IDX) begin
                                state_d = RUN;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Right-edge replication: re-shift the newest sample.
                    r_d[0]      = r_q[1];
                    r_d[1]      = r_q[2];
                    r_d[2]      = r_q[3];
                    r_d[3]      = r_q[3];
                    tap_valid_d = 1'b1;
                    if (fl_cnt_q) begin
                        tap_last_d = 1'b1;
                        state_d    = FILL;
                        fl_cnt_d   = 1'b0;
                    end else begin
                        fl_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            in_cnt_q    <= '0;
            fl_cnt_q    <= 1'b0;
            r_q[0]      <= '0;
            r_q[1]      <= '0;
            r_q[2]      <= '0;
            r_q[3]      <= '0;
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            fl_cnt_q    <= fl_cnt_d;
            r_q         <= r_d;
            tap_valid_q <= tap_valid_d;
            tap_last_q  <= tap_last_d;
        end
    end

    assign tap_0     = r_q[0];
    assign tap_1     = r_q[1];
    assign tap_2     = r_q[2];
    assign tap_3     = r_q[3];
    assign tap_valid = tap_valid_q;
    assign tap_last  = tap_last_q;

endmodule
